// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame streamer.
// FSM state encoding, PCD8544-style init/address commands and default geometry.
package lcd_pkg;

  typedef enum logic [3:0] {
    StRstHold,
    StInit,
    StIdle,
    StAddrX,
    StAddrY,
    StFetch,
    StLoad,
    StStream,
    StDone
  } state_e;

  localparam int unsigned DefCols      = 84;
  localparam int unsigned DefBanks     = 6;
  localparam int unsigned DefRstCycles = 16;
  localparam int unsigned InitLen      = 6;

  // Init sequence: extended set, Vop, temp coeff, bias, basic set, normal mode
  localparam logic [7:0] CmdExtended = 8'h21;
  localparam logic [7:0] CmdVop      = 8'hC0;
  localparam logic [7:0] CmdTempCo   = 8'h06;
  localparam logic [7:0] CmdBias     = 8'h13;
  localparam logic [7:0] CmdBasic    = 8'h20;
  localparam logic [7:0] CmdNormal   = 8'h0C;

  // Column / bank address reset to 0
  localparam logic [7:0] CmdSetX = 8'h80;
  localparam logic [7:0] CmdSetY = 8'h40;

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational table of the panel init command sequence.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] cmd
);

  // Index-to-command lookup; unused indices return 0x00
  always_comb begin
    cmd = 8'h00;
    case (idx)
      3'd0:    cmd = CmdExtended;
      3'd1:    cmd = CmdVop;
      3'd2:    cmd = CmdTempCo;
      3'd3:    cmd = CmdBias;
      3'd4:    cmd = CmdBasic;
      3'd5:    cmd = CmdNormal;
      default: cmd = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams panel reset, init commands and full framebuffer frames as a byte
// stream with valid/ready handshake toward an SPI serializer.
// Optional build macro LCD_INVERT_EN: invert every display-data byte on load.
module lcd_frame_streamer
  import lcd_pkg::*;
#(
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned BANKS      = DefBanks,
  parameter int unsigned RST_CYCLES = DefRstCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_req,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] byte_out,
  output logic       byte_dc,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       lcd_rst,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BankW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned CntW  = $clog2(RST_CYCLES + 1);

  localparam logic [ColW-1:0]  ColLast  = ColW'(COLS - 1);
  localparam logic [BankW-1:0] BankLast = BankW'(BANKS - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(RST_CYCLES - 1);
  localparam logic [2:0]       InitLast = 3'(InitLen - 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [BankW-1:0] bank_q, bank_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_dc_q, byte_dc_d;
  logic             byte_valid_q, byte_valid_d;
  logic [8:0]       fb_addr_q, fb_addr_d;
  logic             lcd_rst_q, lcd_rst_d;

  logic       xfer;
  logic [2:0] rom_idx;
  logic [7:0] rom_cmd;
  logic [7:0] load_byte;

  assign xfer = byte_valid_q & byte_ready;

  // ROM is addressed with the index of the command to be offered next
  assign rom_idx = (state_q == StInit) ? idx_q + 3'd1 : 3'd0;

  lcd_init_rom u_init_rom (
    .idx (rom_idx),
    .cmd (rom_cmd)
  );

  // Data byte as presented downstream
  always_comb begin
`ifdef LCD_INVERT_EN
    load_byte = ~fb_data;
`else
    load_byte = fb_data;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    col_d        = col_q;
    bank_d       = bank_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    byte_out_d   = byte_out_q;
    byte_dc_d    = byte_dc_q;
    byte_valid_d = byte_valid_q;
    fb_addr_d    = fb_addr_q;
    lcd_rst_d    = lcd_rst_q;

    // Requests outside IDLE are remembered once; extras collapse into the same flag
    if (frame_req && (state_q != StIdle)) pending_d = 1'b1;

    unique case (state_q)
      StRstHold: begin
        lcd_rst_d = 1'b0;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d        = '0;
          lcd_rst_d    = 1'b1;
          idx_d        = 3'd0;
          byte_out_d   = rom_cmd;
          byte_dc_d    = 1'b0;
          byte_valid_d = 1'b1;
          state_d      = StInit;
        end
      end
      StInit: begin
        if (xfer) begin
          if (idx_q == InitLast) begin
            byte_valid_d = 1'b0;
            state_d      = StIdle;
          end else begin
            idx_d      = idx_q + 3'd1;
            byte_out_d = rom_cmd;
          end
        end
      end
      StIdle: begin
        if (frame_req || pending_q) begin
          pending_d    = 1'b0;
          byte_out_d   = CmdSetX;
          byte_dc_d    = 1'b0;
          byte_valid_d = 1'b1;
          state_d      = StAddrX;
        end
      end
      StAddrX: begin
        if (xfer) begin
          byte_out_d = CmdSetY;
          state_d    = StAddrY;
        end
      end
      StAddrY: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          col_d        = '0;
          bank_d       = '0;
          fb_addr_d    = 9'd0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        byte_out_d   = load_byte;
        byte_dc_d    = 1'b1;
        byte_valid_d = 1'b1;
        state_d      = StStream;
      end
      StStream: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          if (col_q == ColLast) begin
            if (bank_q == BankLast) begin
              state_d = StDone;
            end else begin
              col_d     = '0;
              bank_d    = bank_q + BankW'(1);
              fb_addr_d = fb_addr_q + 9'd1;
              state_d   = StFetch;
            end
          end else begin
            col_d     = col_q + ColW'(1);
            fb_addr_d = fb_addr_q + 9'd1;
            state_d   = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StRstHold;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRstHold;
      pending_q    <= 1'b0;
      col_q        <= '0;
      bank_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      byte_out_q   <= 8'h00;
      byte_dc_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      fb_addr_q    <= 9'd0;
      lcd_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      col_q        <= col_d;
      bank_q       <= bank_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      byte_out_q   <= byte_out_d;
      byte_dc_q    <= byte_dc_d;
      byte_valid_q <= byte_valid_d;
      fb_addr_q    <= fb_addr_d;
      lcd_rst_q    <= lcd_rst_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign byte_out   = byte_out_q;
  assign byte_dc    = byte_dc_q;
  assign byte_valid = byte_valid_q;
  assign lcd_rst    = lcd_rst_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer: reset values, panel reset/init,
// full frames with and without backpressure, request queueing, mid-frame reset.
module tb_lcd_frame_streamer;

  logic       clk;
  logic       reset;
  logic       frame_req;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic [7:0] byte_out;
  logic       byte_dc;
  logic       byte_valid;
  logic       byte_ready;
  logic       lcd_rst;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int unstable = 0;
  bit fb_const = 1'b0;

  lcd_frame_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .frame_req  (frame_req),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .byte_out   (byte_out),
    .byte_dc    (byte_dc),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .lcd_rst    (lcd_rst),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous framebuffer: data appears one cycle after the address
  always @(posedge clk) fb_data <= fb_const ? 8'h0F : fb_addr[7:0];

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int a);
    logic [7:0] v;
    v = fb_const ? 8'h0F : a[7:0];
`ifdef LCD_INVERT_EN
    v = ~v;
`endif
    return v;
  endfunction

  // Wait for one transfer with the given ready duty; tracks stall stability
  task automatic get_xfer(input int duty, output logic [7:0] b, output logic dc,
                          output bit tmo);
    bit         stalled = 1'b0;
    logic [7:0] pb = 8'h00;
    logic       pdc = 1'b0;
    tmo = 1'b1;
    b   = 8'h00;
    dc  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      byte_ready = ($urandom_range(99) < duty);
      if (stalled && byte_valid && ((byte_out !== pb) || (byte_dc !== pdc))) unstable++;
      if (byte_valid && byte_ready) begin
        b   = byte_out;
        dc  = byte_dc;
        tmo = 1'b0;
        @(posedge clk);
        #1 byte_ready = 1'b0;
        break;
      end
      stalled = byte_valid;
      pb      = byte_out;
      pdc     = byte_dc;
    end
  endtask

  // Collect the two address commands plus ndata data bytes
  task automatic run_frame(input int duty, input int ndata, output int hdr_err,
                           output int data_err, output int tmo_cnt);
    logic [7:0] b;
    logic       dc;
    bit         tmo;
    hdr_err  = 0;
    data_err = 0;
    tmo_cnt  = 0;
    for (int i = 0; i < ndata + 2; i++) begin
      get_xfer(duty, b, dc, tmo);
      if (tmo) begin
        tmo_cnt++;
        break;
      end
      if (i == 0) begin
        if (b !== 8'h80 || dc !== 1'b0) hdr_err++;
      end else if (i == 1) begin
        if (b !== 8'h40 || dc !== 1'b0) hdr_err++;
      end else if (b !== exp_data(i - 2) || dc !== 1'b1) begin
        data_err++;
      end
    end
  endtask

  // Panel reset hold and init command sequence, starting right after release
  task automatic do_init(input string tag);
    logic [7:0] init_exp [6];
    logic [7:0] b;
    logic       dc;
    bit         tmo;
    int         n;
    int         dc_err;
    init_exp = '{8'h21, 8'hC0, 8'h06, 8'h13, 8'h20, 8'h0C};
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (lcd_rst) break;
    end
    chk({tag, "_rst_hold_cycles"}, n, 16);
    dc_err = 0;
    for (int i = 0; i < 6; i++) begin
      get_xfer(100, b, dc, tmo);
      chk($sformatf("%s_init%0d", tag, i), {23'd0, tmo, b}, {24'd0, init_exp[i]});
      if (dc !== 1'b0) dc_err++;
    end
    chk({tag, "_init_dc"}, dc_err, 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, byte_valid, 0);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  initial begin
    int he, de, te;
    reset      = 1'b0;
    frame_req  = 1'b0;
    byte_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_lcd_rst", lcd_rst, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_dc", byte_dc, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", frame_done, 0);

    // Panel reset and init
    reset = 1'b1;
    do_init("boot");

    // Full frame, ready always high
    done_cnt = 0;
    unstable = 0;
    pulse_req();
    run_frame(100, 504, he, de, te);
    chk("f1_hdr", he, 0);
    chk("f1_data", de, 0);
    chk("f1_tmo", te, 0);
    repeat (3) @(negedge clk);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_busy", busy, 0);
    chk("f1_fb_addr_end", fb_addr, 9'd503);

    // Same frame with 30% ready duty
    done_cnt = 0;
    pulse_req();
    run_frame(30, 504, he, de, te);
    chk("f2_hdr", he, 0);
    chk("f2_data", de, 0);
    chk("f2_tmo", te, 0);
    chk("f2_stable", unstable, 0);
    repeat (3) @(negedge clk);
    chk("f2_done_cnt", done_cnt, 1);

    // Three requests during a frame: one extra frame, third dropped
    done_cnt = 0;
    pulse_req();
    fork
      run_frame(100, 504, he, de, te);
      begin
        repeat (3) begin
          repeat (40) @(negedge clk);
          frame_req = 1'b1;
          @(negedge clk);
          frame_req = 1'b0;
        end
      end
    join
    chk("f3_data", he + de + te, 0);
    run_frame(100, 504, he, de, te);
    chk("f4_data", he + de + te, 0);
    repeat (60) @(negedge clk);
    chk("f4_done_cnt", done_cnt, 2);
    chk("f4_busy", busy, 0);

    // Reset at data byte 200
    done_cnt = 0;
    pulse_req();
    run_frame(100, 200, he, de, te);
    chk("f5_partial", he + de + te, 0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", byte_valid, 0);
    chk("mid_rst_lcd_rst", lcd_rst, 0);
    chk("mid_rst_byte_out", byte_out, 8'h00);
    chk("mid_rst_fb_addr", fb_addr, 0);
    chk("mid_rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_init("rerun");
    chk("mid_rst_no_done", done_cnt, 0);

    // Constant framebuffer pattern
    fb_const = 1'b1;
    done_cnt = 0;
    pulse_req();
    run_frame(100, 504, he, de, te);
    chk("f6_hdr", he, 0);
    chk("f6_data", de + te, 0);
    repeat (3) @(negedge clk);
    chk("f6_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_frame_streamer.md
LCD_FRAME_STREAMER -- requirements
Module: lcd_frame_streamer

Interface
REQ-001 Parameter COLS, default 84: display columns per bank.
REQ-002 Parameter BANKS, default 6: 8-pixel-high banks per frame.
REQ-003 Parameter RST_CYCLES, default 16: clk cycles lcd_rst is held low after reset.
REQ-004 clk  in  1  sole clock, all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 frame_req  in  1  single-cycle request to stream one full frame.
REQ-007 fb_addr  out  9  framebuffer read address, bank*COLS+col.
REQ-008 fb_data  in  8  framebuffer read data, valid exactly 1 cycle after fb_addr.
REQ-009 byte_out  out  8  byte offered to the downstream SPI stage.
REQ-010 byte_dc  out  1  0 = command, 1 = display data; qualifies byte_out.
REQ-011 byte_valid  out  1  byte_out/byte_dc valid.
REQ-012 byte_ready  in  1  downstream SPI stage accepts byte this cycle.
REQ-013 lcd_rst  out  1  active-low LCD panel reset.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse after the last data byte of a frame is accepted.

Function
REQ-016 A transfer occurs on a posedge with byte_valid=1 and byte_ready=1; byte_out/byte_dc SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-017 FSM states: RST_HOLD, INIT, IDLE, ADDR_X, ADDR_Y, FETCH, LOAD, STREAM, DONE.
REQ-018 RST_HOLD: lcd_rst=0 for RST_CYCLES cycles, then lcd_rst=1 and go to INIT.
REQ-019 INIT: send commands 0x21, 0xC0, 0x06, 0x13, 0x20, 0x0C in order, dc=0, one per transfer; after the 6th transfer go to IDLE.
REQ-020 IDLE: frame_req=1 or pending=1 -> ADDR_X, clearing pending.
REQ-021 ADDR_X sends 0x80 (dc=0); ADDR_Y sends 0x40 (dc=0); then FETCH with col=0, bank=0.
REQ-022 FETCH drives fb_addr for one cycle -> LOAD; LOAD registers fb_data into byte_out, dc=1, byte_valid=1 -> STREAM.
REQ-023 STREAM on transfer: col==COLS-1 and bank==BANKS-1 -> DONE; col==COLS-1 -> col=0, bank+1, FETCH; else col+1, FETCH.
REQ-024 DONE asserts frame_done for one cycle -> IDLE.
REQ-025 frame_req while busy SHALL set a 1-deep pending flag; further requests while pending is set are dropped.
REQ-026 frame_req in INIT or RST_HOLD SHALL set pending; the frame starts on the first IDLE cycle.
REQ-027 Frame length SHALL be exactly 2 command + COLS*BANKS data transfers (506 at defaults); fb_addr spans 0..503 with no wrap beyond.
REQ-028 byte_valid SHALL be 0 in RST_HOLD, IDLE, FETCH, LOAD, DONE.
REQ-029 Downstream stall of any length SHALL not alter byte order or drop bytes.

Reset
REQ-030 reset=0 SHALL asynchronously force state=RST_HOLD, lcd_rst=0, byte_valid=0, byte_out=0x00, byte_dc=0, fb_addr=0, busy=1, frame_done=0, pending=0, counters=0.
REQ-031 Reset mid-frame SHALL abandon the frame; after release the full RST_HOLD+INIT sequence reruns before any frame.

Configuration
REQ-032 Macro LCD_INVERT_EN: defined -> every dc=1 byte is bitwise inverted on load (commands unchanged); undefined -> data passes unmodified.

Structure
REQ-033 Shared package lcd_pkg SHALL hold the FSM state typedef, init command constants, 0x80/0x40 address commands and default geometry.
REQ-034 Init command table SHALL be a sub-module lcd_init_rom (3-bit index in, 8-bit command out, combinational).

Verification
REQ-035 Release reset, byte_ready=1 -> lcd_rst low 16 cycles, then 0x21,0xC0,0x06,0x13,0x20,0x0C with dc=0, then busy=0.
REQ-036 frame_req in IDLE, fb_data=addr[7:0], byte_ready=1 -> 0x80, 0x40 (dc=0), then 504 dc=1 bytes 0x00..0xF7 pattern, frame_done once.
REQ-037 byte_ready random 30% duty -> identical byte sequence to REQ-036, byte_out stable during each stall.
REQ-038 Two frame_req pulses during a frame -> exactly one additional frame follows; a third is dropped.
REQ-039 Reset asserted at data byte 200 -> outputs at reset values immediately, init sequence repeats, no frame_done.
REQ-040 LCD_INVERT_EN defined, fb_data=0x0F -> data bytes 0xF0, init/address bytes unchanged.
